// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed seven-segment scan driver. It double-buffers the
// segment patterns and swaps them only at frame boundaries, so a value is never
// shown torn.
module seg_scan #(
  parameter int         NUM_DIGITS    = 4,
  parameter int         REFRESH_DIV   = 50000,
  parameter int         BLANK_CYCLES  = 2,
  parameter int         AN_ACTIVE_LOW = 1,
  parameter logic [6:0] SEG_OFF       = 7'b1111111
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7*NUM_DIGITS-1:0]   digits_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     blank_in,
  input  logic                      upd_req,
  output logic                      upd_ack,
  output logic [NUM_DIGITS-1:0]     an,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic                      frame_start
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0]      BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = {NUM_DIGITS{AN_ACTIVE_LOW != 0}};

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             tc, fb;

  // Shadow buffer; digit k lives in pat_q[k], same layout as digits_in.
  logic [NUM_DIGITS-1:0][6:0] pat_q, pat_d;
  logic [NUM_DIGITS-1:0]      sdp_q, sdp_d;
  logic [NUM_DIGITS-1:0]      sblank_q, sblank_d;

  logic [NUM_DIGITS-1:0] an_q, an_d, onehot;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  fs_q, fs_d;

  // Prescaler and digit index; the frame boundary is the last cycle of the last digit.
  always_comb begin
    tc    = (cnt_q == CNT_LAST);
    fb    = tc && (idx_q == IDX_LAST);
    cnt_d = tc ? '0 : cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (tc) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
  end

  // Shadow capture at the frame boundary only; ack is combinational and masked by reset.
  always_comb begin
    pat_d    = pat_q;
    sdp_d    = sdp_q;
    sblank_d = sblank_q;
    upd_ack  = fb && upd_req && !rst;
    if (fb && upd_req) begin
      pat_d    = digits_in;
      sdp_d    = dp_in;
      sblank_d = blank_in;
    end
  end

  // Next output values: dark during the anti-ghosting window, then the current digit.
  always_comb begin
    an_d   = AN_OFF;
    seg_d  = SEG_OFF;
    dp_d   = 1'b0;
    onehot = NUM_DIGITS'(1) << idx_q;
    fs_d   = (cnt_q == '0) && (idx_q == '0);
    if (cnt_q >= BLANK_END) begin
      an_d = (AN_ACTIVE_LOW != 0) ? ~onehot : onehot;
      if (!sblank_q[idx_q]) begin
        seg_d = pat_q[idx_q];
        dp_d  = sdp_q[idx_q];
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      pat_q    <= {NUM_DIGITS{SEG_OFF}};
      sdp_q    <= '0;
      sblank_q <= '1;
      an_q     <= AN_OFF;
      seg_q    <= SEG_OFF;
      dp_q     <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      pat_q    <= pat_d;
      sdp_q    <= sdp_d;
      sblank_q <= sblank_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      fs_q     <= fs_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = fs_q;

endmodule
